axil2apb_bridge: RTL

Single-outstanding AXI4-Lite slave to APB4 master bridge that sits in front of the peripheral set (EF_TCC32 timers, RTC) inside the periphery wrapper. It accepts one AXI-Lite read or write at a time, decodes the target peripheral slot from the address, and runs one APB setup/access transfer. It returns the APB result as an AXI-Lite response: OKAY, SLVERR from PSLVERR, or DECERR for unmapped addresses.

---
 rtl/axil2apb_bridge.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/axil2apb_bridge.sv
// Single-outstanding AXI4-Lite slave to APB4 master bridge with slot decode.
// Optional APB wait timeout enabled by defining AXIL2APB_TIMEOUT_EN.
module axil2apb_bridge #(
  parameter int unsigned               AXI_LITE_AW    = 32,
  parameter int unsigned               AXI_LITE_DW    = 32,
  parameter int unsigned               APB_AW         = 32,
  parameter int unsigned               APB_DW         = 32,
  parameter logic [AXI_LITE_AW-1:0]    PERIPH_BA      = '0,
  parameter int unsigned               NUM_SLV        = 2,
  parameter int unsigned               SLV_SPAN       = 32'h1000,
  parameter int unsigned               TIMEOUT_CYCLES = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [AXI_LITE_AW-1:0]       aw_addr,
  input  logic [2:0]                   aw_prot,
  input  logic                         aw_valid,
  output logic                         aw_ready,
  input  logic [AXI_LITE_DW-1:0]       w_data,
  input  logic [AXI_LITE_DW/8-1:0]     w_strb,
  input  logic                         w_valid,
  output logic                         w_ready,
  output logic [1:0]                   b_resp,
  output logic                         b_valid,
  input  logic                         b_ready,
  input  logic [AXI_LITE_AW-1:0]       ar_addr,
  input  logic [2:0]                   ar_prot,
  input  logic                         ar_valid,
  output logic                         ar_ready,
  output logic [AXI_LITE_DW-1:0]       r_data,
  output logic [1:0]                   r_resp,
  output logic                         r_valid,
  input  logic                         r_ready,
  output logic [APB_AW-1:0]            paddr,
  output logic [2:0]                   pprot,
  output logic [NUM_SLV-1:0]           psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [APB_DW-1:0]            pwdata,
  output logic [APB_DW/8-1:0]          pstrb,
  input  logic [NUM_SLV*APB_DW-1:0]    prdata,
  input  logic [NUM_SLV-1:0]           pready,
  input  logic [NUM_SLV-1:0]           pslverr
);

  localparam int unsigned SPAN_LG = $clog2(SLV_SPAN);
  localparam int unsigned SLOT_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [AXI_LITE_AW-1:0] SPAN_MASK = AXI_LITE_AW'(SLV_SPAN - 1);
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  if (AXI_LITE_DW != APB_DW) begin : g_dw_chk
    $error("AXI_LITE_DW must equal APB_DW");
  end
  if ((SLV_SPAN & (SLV_SPAN - 1)) != 0) begin : g_span_chk
    $error("SLV_SPAN must be a power of two");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_to_chk
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_e;

  state_e              state;
  logic                last_was_write;
  logic                txn_write;
  logic [SLOT_W-1:0]   slot_q;

  logic                wr_req_c, grant_rd_c, grant_wr_c, hs_wr_c, hs_rd_c, in_range_c;
  logic [AXI_LITE_AW-1:0] dec_addr_c, offset_c;
  logic [SLOT_W-1:0]   slot_c;
  logic                sel_ready_c, sel_err_c;
  logic [APB_DW-1:0]   sel_rdata_c;

  // Round-robin between read and write when both are pending
  assign wr_req_c   = aw_valid & w_valid;
  assign grant_rd_c = ar_valid & (~wr_req_c | last_was_write);
  assign grant_wr_c = wr_req_c & ~grant_rd_c;
  assign hs_wr_c    = aw_ready & w_ready & wr_req_c;
  assign hs_rd_c    = ar_ready & ar_valid;

  assign dec_addr_c = hs_wr_c ? aw_addr : ar_addr;
  assign offset_c   = dec_addr_c - PERIPH_BA;
  assign in_range_c = (dec_addr_c >= PERIPH_BA) &&
                      ((offset_c >> SPAN_LG) < AXI_LITE_AW'(NUM_SLV));
  assign slot_c     = SLOT_W'(offset_c >> SPAN_LG);

  assign sel_ready_c = pready[slot_q];
  assign sel_err_c   = pslverr[slot_q];
  assign sel_rdata_c = prdata[APB_DW*32'(slot_q) +: APB_DW];

`ifdef AXIL2APB_TIMEOUT_EN
  localparam int unsigned TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit_c;
  assign to_hit_c = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= ST_IDLE;
      last_was_write <= 1'b1;
      txn_write      <= 1'b0;
      slot_q         <= '0;
      aw_ready       <= 1'b0;
      w_ready        <= 1'b0;
      ar_ready       <= 1'b0;
      b_valid        <= 1'b0;
      b_resp         <= '0;
      r_valid        <= 1'b0;
      r_resp         <= '0;
      r_data         <= '0;
      paddr          <= '0;
      pprot          <= '0;
      psel           <= '0;
      penable        <= 1'b0;
      pwrite         <= 1'b0;
      pwdata         <= '0;
      pstrb          <= '0;
`ifdef AXIL2APB_TIMEOUT_EN
      to_cnt         <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (aw_ready || ar_ready) begin
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            ar_ready <= 1'b0;
            if (hs_wr_c || hs_rd_c) begin
              txn_write <= hs_wr_c;
              if (in_range_c) begin
                paddr  <= APB_AW'(offset_c & SPAN_MASK);
                pprot  <= hs_wr_c ? aw_prot : ar_prot;
                pwrite <= hs_wr_c;
                pstrb  <= hs_wr_c ? (APB_DW/8)'(w_strb) : '0;
                if (hs_wr_c) pwdata <= APB_DW'(w_data);
                slot_q <= slot_c;
                psel   <= NUM_SLV'(1) << slot_c;
                state  <= ST_SETUP;
              end else if (hs_wr_c) begin
                b_valid <= 1'b1;
                b_resp  <= RESP_DECERR;
                state   <= ST_RESP;
              end else begin
                r_valid <= 1'b1;
                r_resp  <= RESP_DECERR;
                r_data  <= '0;
                state   <= ST_RESP;
              end
            end
          end else if (grant_rd_c) begin
            ar_ready       <= 1'b1;
            last_was_write <= 1'b0;
          end else if (grant_wr_c) begin
            aw_ready       <= 1'b1;
            w_ready        <= 1'b1;
            last_was_write <= 1'b1;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
`ifdef AXIL2APB_TIMEOUT_EN
          to_cnt  <= '0;
`endif
        end
        ST_ACCESS: begin
          if (sel_ready_c) begin
            psel    <= '0;
            penable <= 1'b0;
            state   <= ST_RESP;
            if (txn_write) begin
              b_valid <= 1'b1;
              b_resp  <= {sel_err_c, 1'b0};
            end else begin
              r_valid <= 1'b1;
              r_resp  <= {sel_err_c, 1'b0};
              r_data  <= AXI_LITE_DW'(sel_rdata_c);
            end
          end
`ifdef AXIL2APB_TIMEOUT_EN
          // Abandon a stalled slave; any later pready is ignored
          else if (to_hit_c) begin
            psel    <= '0;
            penable <= 1'b0;
            state   <= ST_RESP;
            if (txn_write) begin
              b_valid <= 1'b1;
              b_resp  <= RESP_SLVERR;
            end else begin
              r_valid <= 1'b1;
              r_resp  <= RESP_SLVERR;
              r_data  <= '0;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        ST_RESP: begin
          // Arbitrate on the response handshake so the next request lands one cycle later
          if ((b_valid && b_ready) || (r_valid && r_ready)) begin
            b_valid <= 1'b0;
            r_valid <= 1'b0;
            state   <= ST_IDLE;
            if (grant_rd_c) begin
              ar_ready       <= 1'b1;
              last_was_write <= 1'b0;
            end else if (grant_wr_c) begin
              aw_ready       <= 1'b1;
              w_ready        <= 1'b1;
              last_was_write <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
